// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
// Holds the opcode constants, the opcode class, the ALUOp, writeback-select and
// trap-cause encodings, and the control FSM state type.
package rv_pkg;

  localparam int unsigned OP_W = 7;

  // Base opcodes decoded by the core
  localparam logic [OP_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OPC_I     = 7'b0010011;
  localparam logic [OP_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OP_W-1:0] OPC_BR    = 7'b1100011;
  localparam logic [OP_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OPC_JALR  = 7'b1100111;
  localparam logic [OP_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OPC_AUIPC = 7'b0010111;
  localparam logic [OP_W-1:0] OPC_ENV   = 7'b1110011;

  // Opcode class; CL_NONE is the reset value and also marks illegal opcodes
  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_R      = 4'd1,
    CL_I      = 4'd2,
    CL_LOAD   = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_JAL    = 4'd6,
    CL_JALR   = 4'd7,
    CL_LUI    = 4'd8,
    CL_AUIPC  = 4'd9,
    CL_ENV    = 4'd10
  } op_class_e;

  typedef enum logic [2:0] {
    ALU_LDST  = 3'd0,
    ALU_BR    = 3'd1,
    ALU_RI    = 3'd2,
    ALU_JMP   = 3'd3,
    ALU_LUI   = 3'd4,
    ALU_AUIPC = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL = 2'd0,
    CAUSE_ENV     = 2'd1,
    CAUSE_BUS     = 2'd2
  } trap_cause_e;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

endpackage

// File: rtl/rv_opdec.sv
// Combinational opcode decoder: maps the 7-bit opcode onto an opcode class
// and flags anything outside the RV32I base set as illegal.
//   op          opcode field of the instruction
//   op_class_c  decoded class (CL_NONE when illegal)
//   illegal_c   opcode is not a recognised RV32I base opcode
module rv_opdec
  import rv_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_e       op_class_c,
  output logic            illegal_c
);

  always_comb begin
    op_class_c = CL_NONE;
    illegal_c  = 1'b0;
    case (op)
      OPC_R:     op_class_c = CL_R;
      OPC_I:     op_class_c = CL_I;
      OPC_LOAD:  op_class_c = CL_LOAD;
      OPC_STORE: op_class_c = CL_STORE;
      OPC_BR:    op_class_c = CL_BRANCH;
      OPC_JAL:   op_class_c = CL_JAL;
      OPC_JALR:  op_class_c = CL_JALR;
      OPC_LUI:   op_class_c = CL_LUI;
      OPC_AUIPC: op_class_c = CL_AUIPC;
      OPC_ENV:   op_class_c = CL_ENV;
      default:   illegal_c  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_control_mc.sv
// Multi-cycle RV32I control unit. A Moore FSM walks FETCH/DECODE/EXEC/MEM/WB,
// waits on instruction/data memory acks under a bus-timeout watchdog, and
// raises traps for illegal opcodes, ECALL/EBREAK and bus timeouts.
// Outputs are decoded from the state plus the opcode class latched in DECODE.
//   clk_i, rst_n_i         clock, synchronous active-low reset
//   instr_op_i             opcode of the instruction register
//   imem_ack_i/dmem_ack_i  memory handshakes
//   branch_taken_i         branch comparator result
//   trap_ack_i             trap handler accepted the trap
//   imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, reg_we_o, pc_we_o, branch_o,
//   pc_incr_sel_o, alu_op_o, alu_src_o, mem_to_reg_o   datapath controls
//   trap_o, trap_cause_o   trap pending and its cause
//   busy_o                 high in every state except RST
module rv_control_mc
  import rv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5,
  parameter bit          ENV_EN      = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [OP_W-1:0] instr_op_i,
  input  logic            imem_ack_i,
  input  logic            dmem_ack_i,
  input  logic            branch_taken_i,
  input  logic            trap_ack_i,
  output logic            imem_req_o,
  output logic            ir_we_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic            reg_we_o,
  output logic            pc_we_o,
  output logic            branch_o,
  output logic            pc_incr_sel_o,
  output logic [2:0]      alu_op_o,
  output logic            alu_src_o,
  output logic [1:0]      mem_to_reg_o,
  output logic            trap_o,
  output logic [1:0]      trap_cause_o,
  output logic            busy_o
);

  localparam bit              WD_EN   = (MEM_TIMEOUT != 0);
  // Count value of the last ack-less cycle tolerated before the bus trap
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  op_class_e       cls_q, cls_d;
  trap_cause_e     cause_q, cause_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  op_class_e dec_class;
  logic      dec_illegal;
  logic      wd_expire;

  rv_opdec u_opdec (
    .op         (instr_op_i),
    .op_class_c (dec_class),
    .illegal_c  (dec_illegal)
  );

  // Watchdog fires on the MEM_TIMEOUT-th consecutive cycle without an ack
  assign wd_expire = WD_EN && (cnt_q == TO_LAST);

  // State, class, cause and watchdog registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RST;
      cls_q   <= CL_NONE;
      cause_q <= CAUSE_ILLEGAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and control decode
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cause_d       = cause_q;
    cnt_d         = '0;
    imem_req_o    = 1'b0;
    ir_we_o       = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    reg_we_o      = 1'b0;
    pc_we_o       = 1'b0;
    branch_o      = 1'b0;
    pc_incr_sel_o = 1'b0;
    alu_op_o      = ALU_LDST;
    alu_src_o     = 1'b0;
    mem_to_reg_o  = WB_ALU;
    trap_o        = 1'b0;
    trap_cause_o  = CAUSE_ILLEGAL;
    busy_o        = 1'b1;

    case (state_q)
      ST_RST: begin
        busy_o  = 1'b0;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o = 1'b1;
          state_d = ST_DECODE;
        end else if (wd_expire) begin
          cause_d = CAUSE_BUS;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      ST_DECODE: begin
        cls_d = dec_class;
        if (dec_illegal) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end else if (dec_class == CL_ENV) begin
          if (ENV_EN) begin
            cause_d = CAUSE_ENV;
            state_d = ST_TRAP;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_q)
          CL_BRANCH:        alu_op_o = ALU_BR;
          CL_R, CL_I:       alu_op_o = ALU_RI;
          CL_JAL, CL_JALR:  alu_op_o = ALU_JMP;
          CL_LUI:           alu_op_o = ALU_LUI;
          CL_AUIPC:         alu_op_o = ALU_AUIPC;
          default:          alu_op_o = ALU_LDST;
        endcase
        alu_src_o = (cls_q inside {CL_I, CL_LOAD, CL_STORE, CL_JALR, CL_LUI, CL_AUIPC});
        if (cls_q == CL_BRANCH) begin
          branch_o = branch_taken_i;
          pc_we_o  = 1'b1;
          state_d  = ST_FETCH;
        end else if (cls_q inside {CL_LOAD, CL_STORE}) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (cls_q == CL_STORE);
        if (dmem_ack_i) begin
          if (cls_q == CL_STORE) begin
            pc_we_o = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wd_expire) begin
          cause_d = CAUSE_BUS;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      ST_WB: begin
        pc_we_o  = 1'b1;
        // An ENV retired as a NOP only advances the PC
        reg_we_o = (cls_q != CL_ENV);
        if (cls_q == CL_LOAD) begin
          mem_to_reg_o = WB_MEM;
        end else if (cls_q inside {CL_JAL, CL_JALR}) begin
          mem_to_reg_o = WB_PC4;
          branch_o     = 1'b1;
        end
        pc_incr_sel_o = (cls_q == CL_JALR);
        state_d       = ST_FETCH;
      end

      ST_TRAP: begin
        trap_o       = 1'b1;
        trap_cause_o = cause_q;
        if (trap_ack_i) begin
          pc_we_o = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: begin
        busy_o  = 1'b0;
        state_d = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_control_mc.sv
// Bench for rv_control_mc. Two instances: A (MEM_TIMEOUT=4, ENV_EN=1) and
// B (watchdog off, ENV_EN=0); one is held in reset while the other runs.
// Each instruction is expanded from the architectural rules into a list of
// per-cycle input/expected-output steps that is then played against the DUT.
module tb_rv_control_mc;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       pc_we;
    logic       branch;
    logic       pc_incr;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] m2r;
    logic       trap;
    logic [1:0] cause;
    logic       busy;
  } outs_t;

  typedef struct packed {
    logic  ia;
    logic  da;
    logic  ta;
    outs_t e;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [6:0] op;
  logic       imem_ack, dmem_ack, taken, trap_ack;
  outs_t      o_a, o_b;
  bit         sel;
  int         m_to;
  bit         m_env;
  int         checks = 0;
  int         errors = 0;
  step_t      q[$];
  string      tq[$];

  always #5 clk = ~clk;

  rv_control_mc #(.MEM_TIMEOUT(4), .TO_W(5), .ENV_EN(1'b1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_a), .instr_op_i(op), .imem_ack_i(imem_ack),
    .dmem_ack_i(dmem_ack), .branch_taken_i(taken), .trap_ack_i(trap_ack),
    .imem_req_o(o_a.imem_req), .ir_we_o(o_a.ir_we), .dmem_req_o(o_a.dmem_req),
    .dmem_we_o(o_a.dmem_we), .reg_we_o(o_a.reg_we), .pc_we_o(o_a.pc_we),
    .branch_o(o_a.branch), .pc_incr_sel_o(o_a.pc_incr), .alu_op_o(o_a.alu_op),
    .alu_src_o(o_a.alu_src), .mem_to_reg_o(o_a.m2r), .trap_o(o_a.trap),
    .trap_cause_o(o_a.cause), .busy_o(o_a.busy)
  );

  rv_control_mc #(.MEM_TIMEOUT(0), .TO_W(5), .ENV_EN(1'b0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_b), .instr_op_i(op), .imem_ack_i(imem_ack),
    .dmem_ack_i(dmem_ack), .branch_taken_i(taken), .trap_ack_i(trap_ack),
    .imem_req_o(o_b.imem_req), .ir_we_o(o_b.ir_we), .dmem_req_o(o_b.dmem_req),
    .dmem_we_o(o_b.dmem_we), .reg_we_o(o_b.reg_we), .pc_we_o(o_b.pc_we),
    .branch_o(o_b.branch), .pc_incr_sel_o(o_b.pc_incr), .alu_op_o(o_b.alu_op),
    .alu_src_o(o_b.alu_src), .mem_to_reg_o(o_b.m2r), .trap_o(o_b.trap),
    .trap_cause_o(o_b.cause), .busy_o(o_b.busy)
  );

  // Architectural opcode rules
  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                     7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [6:0] o);
    case (o)
      7'b1100011:             return 3'd1;
      7'b0110011, 7'b0010011: return 3'd2;
      7'b1101111, 7'b1100111: return 3'd3;
      7'b0110111:             return 3'd4;
      7'b0010111:             return 3'd5;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic alu_src_of(input logic [6:0] o);
    return o inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  task automatic push(input logic ia, input logic da, input logic ta, input outs_t e, input string tag);
    step_t s;
    s.ia = ia; s.da = da; s.ta = ta; s.e = e;
    q.push_back(s);
    tq.push_back(tag);
  endtask

  // Expand one instruction into expected cycles. fw/mw: wait cycles before the
  // imem/dmem ack; tw: cycles before trap_ack. Uses m_to, m_env and taken.
  task automatic build(input logic [6:0] o, input int fw, input int mw, input int tw);
    outs_t       e;
    bit          do_trap, do_wb, do_mem;
    logic [1:0]  cause;
    bit          is_ld, is_st, is_env, is_jal, is_jalr;
    is_ld   = (o == 7'b0000011);
    is_st   = (o == 7'b0100011);
    is_env  = (o == 7'b1110011);
    is_jal  = (o == 7'b1101111);
    is_jalr = (o == 7'b1100111);
    do_trap = 1'b0; do_wb = 1'b0; do_mem = 1'b0; cause = 2'd0;

    for (int k = 0; k < 1000; k++) begin
      e = '0; e.busy = 1'b1; e.imem_req = 1'b1;
      if (k == fw) begin
        e.ir_we = 1'b1;
        push(1'b1, 1'b0, 1'b0, e, "fetch_ack");
        break;
      end
      push(1'b0, 1'b0, 1'b0, e, "fetch_wait");
      if (m_to != 0 && k == m_to - 1) begin
        do_trap = 1'b1; cause = 2'd2;
        break;
      end
    end

    if (!do_trap) begin
      e = '0; e.busy = 1'b1;
      push(1'b0, 1'b0, 1'b0, e, "decode");
      if (!is_legal(o)) begin
        do_trap = 1'b1; cause = 2'd0;
      end else if (is_env) begin
        if (m_env) begin do_trap = 1'b1; cause = 2'd1; end
        else do_wb = 1'b1;
      end else begin
        e = '0; e.busy = 1'b1;
        e.alu_op  = alu_op_of(o);
        e.alu_src = alu_src_of(o);
        if (o == 7'b1100011) begin
          e.branch = taken; e.pc_we = 1'b1;
        end else if (is_ld || is_st) begin
          do_mem = 1'b1;
        end else begin
          do_wb = 1'b1;
        end
        push(1'b0, 1'b0, 1'b0, e, "exec");
      end
    end

    if (do_mem) begin
      for (int k = 0; k < 1000; k++) begin
        e = '0; e.busy = 1'b1; e.dmem_req = 1'b1; e.dmem_we = is_st;
        if (k == mw) begin
          e.pc_we = is_st;
          do_wb   = is_ld;
          push(1'b0, 1'b1, 1'b0, e, "mem_ack");
          break;
        end
        push(1'b0, 1'b0, 1'b0, e, "mem_wait");
        if (m_to != 0 && k == m_to - 1) begin
          do_trap = 1'b1; cause = 2'd2;
          break;
        end
      end
    end

    if (do_wb) begin
      e = '0; e.busy = 1'b1; e.pc_we = 1'b1;
      e.reg_we  = !is_env;
      e.m2r     = is_ld ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
      e.branch  = is_jal || is_jalr;
      e.pc_incr = is_jalr;
      push(1'b0, 1'b0, 1'b0, e, "wb");
    end

    if (do_trap) begin
      for (int k = 0; k <= tw; k++) begin
        e = '0; e.busy = 1'b1; e.trap = 1'b1; e.cause = cause;
        e.pc_we = (k == tw);
        push(1'b0, 1'b0, (k == tw), e, (k == tw) ? "trap_ack" : "trap_wait");
      end
    end
  endtask

  task automatic check(input outs_t exp, input string tag);
    outs_t obs;
    obs = sel ? o_b : o_a;
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s (dut %0d op %b): observed %h expected %h", tag, sel, op, obs, exp);
    end
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_b = v; else rst_a = v;
  endtask

  // Play up to n queued steps; optionally drop reset during the last one
  task automatic play(input int n, input bit rst_last);
    step_t s;
    string t;
    int    i;
    i = 0;
    while (q.size() > 0 && i < n) begin
      s = q.pop_front();
      t = tq.pop_front();
      imem_ack = s.ia; dmem_ack = s.da; trap_ack = s.ta;
      if (rst_last && (q.size() == 0 || i == n - 1)) set_rst(1'b0);
      #4;
      check(s.e, t);
      @(posedge clk); #1;
      i++;
    end
    q.delete();
    tq.delete();
    imem_ack = 1'b0; dmem_ack = 1'b0; trap_ack = 1'b0;
  endtask

  // n_low cycles in reset, then the single RST cycle after release
  task automatic rst_cycles(input int n_low);
    for (int i = 0; i < n_low; i++) begin
      set_rst(1'b0);
      #4; check('0, "rst_low");
      @(posedge clk); #1;
    end
    set_rst(1'b1);
    #4; check('0, "rst_exit");
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [6:0] o, input logic tk, input int fw, input int mw, input int tw);
    op = o; taken = tk;
    build(o, fw, mw, tw);
    play(100000, 1'b0);
  endtask

  logic [6:0] legal_ops [10];

  initial begin
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    rst_a = 1'b0; rst_b = 1'b0; op = '0; taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; trap_ack = 1'b0;
    sel = 1'b0; m_to = 4; m_env = 1'b1;
    @(posedge clk); #1;
    rst_cycles(2);

    // Directed: R, load with dmem wait, store, taken branch, JALR
    run(7'b0110011, 1'b0, 0, 0, 0);
    run(7'b0000011, 1'b0, 0, 3, 0);
    run(7'b0100011, 1'b0, 1, 0, 0);
    run(7'b1100011, 1'b1, 0, 0, 0);
    run(7'b1100011, 1'b0, 2, 0, 0);
    run(7'b1100111, 1'b0, 0, 0, 0);
    run(7'b1101111, 1'b1, 0, 0, 0);
    run(7'b0110111, 1'b0, 0, 0, 0);
    // Traps: illegal held 5 cycles, ECALL, fetch/mem timeouts, late acks
    run(7'b0000000, 1'b0, 0, 0, 5);
    run(7'b1110011, 1'b0, 0, 0, 1);
    run(7'b0110011, 1'b0, 500, 0, 2);
    run(7'b0110011, 1'b0, 3, 0, 0);
    run(7'b0000011, 1'b0, 0, 500, 0);
    run(7'b0100011, 1'b0, 0, 3, 0);

    // Reset while waiting in MEM
    op = 7'b0000011; taken = 1'b0;
    build(op, 0, 3, 0);
    play(4, 1'b1);
    rst_cycles(1);

    // Random instruction stream on A
    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 9)];
      run(o, 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
    end

    // Instance B: ENV retires as NOP, no watchdog
    rst_a = 1'b0;
    sel = 1'b1; m_to = 0; m_env = 1'b0;
    rst_cycles(2);
    run(7'b1110011, 1'b0, 0, 0, 0);
    run(7'b0000011, 1'b0, 10, 12, 0);
    run(7'b0000000, 1'b0, 0, 0, 2);
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 9)];
      run(o, 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
